// File: rtl/cpu_defs.sv
// Shared controller/datapath/decoder definitions: FSM states, bus codes and
// instruction field values.
package cpu_defs;

   typedef enum logic [4:0] {
      S_RST, S_IF1, S_IF2, S_UPC, S_DEC,
      S_WIMM, S_GETA, S_GETB, S_ALU, S_WREG,
      S_ADDR, S_LADDR, S_MRD, S_MWB,
      S_SGETB, S_SALU, S_SWR,
      S_BR, S_HALT
   } state_t;

   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_READ  = 2'b01;
   localparam logic [1:0] MEM_WRITE = 2'b10;

   localparam logic [1:0] VSEL_C    = 2'b00;
   localparam logic [1:0] VSEL_PC   = 2'b01;
   localparam logic [1:0] VSEL_IMM  = 2'b10;
   localparam logic [1:0] VSEL_MEM  = 2'b11;

   localparam logic [2:0] NSEL_RM   = 3'b001;
   localparam logic [2:0] NSEL_RD   = 3'b010;
   localparam logic [2:0] NSEL_RN   = 3'b100;

   localparam logic [2:0] OPC_BR    = 3'b001;
   localparam logic [2:0] OPC_LDR   = 3'b011;
   localparam logic [2:0] OPC_STR   = 3'b100;
   localparam logic [2:0] OPC_ALU   = 3'b101;
   localparam logic [2:0] OPC_MOV   = 3'b110;
   localparam logic [2:0] OPC_HALT  = 3'b111;

   localparam logic [1:0] OP_MOVR   = 2'b00;
   localparam logic [1:0] OP_MOVI   = 2'b10;
   localparam logic [1:0] OP_ADD    = 2'b00;
   localparam logic [1:0] OP_CMP    = 2'b01;
   localparam logic [1:0] OP_MVN    = 2'b11;
   localparam logic [1:0] OP_MEM    = 2'b00;

   // MOV Rd,Rm and MVN read only Rm, so they skip GETA and pass B through.
   function automatic logic b_only(input logic [2:0] opcode, input logic [1:0] op);
      return (opcode == OPC_MOV && op == OP_MOVR) || (opcode == OPC_ALU && op == OP_MVN);
   endfunction

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluation from the status flags.
module cond_eval (
   input  logic [2:0] cond,
   input  logic       Z,
   input  logic       N,
   input  logic       V,
   output logic       taken
);

   always_comb begin
      taken = 1'b0;
      case (cond)
         3'b000:  taken = 1'b1;
         3'b001:  taken = Z;
         3'b010:  taken = ~Z;
         3'b011:  taken = N ^ V;
         3'b100:  taken = (N ^ V) | Z;
         default: taken = 1'b0;
      endcase
   end

endmodule

// File: rtl/cpu_controller.sv
// Moore FSM sequencing fetch, decode and execute for the simple CPU datapath.
module cpu_controller
   import cpu_defs::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] opcode,
   input  logic [1:0] op,
   input  logic [2:0] cond,
   input  logic       Z,
   input  logic       N,
   input  logic       V,
   output logic [2:0] nsel,
   output logic       loada,
   output logic       loadb,
   output logic       loadc,
   output logic       loads,
   output logic       write,
   output logic       asel,
   output logic       bsel,
   output logic [1:0] vsel,
   output logic       load_ir,
   output logic       load_pc,
   output logic       reset_pc,
   output logic       pc_sel,
   output logic       addr_sel,
   output logic       load_addr,
   output logic [1:0] mem_cmd,
   output logic       halted
);

   state_t state, next_state;
   logic   br_taken;
   logic   is_mem;

   assign is_mem = (opcode == OPC_LDR || opcode == OPC_STR) && op == OP_MEM;

   cond_eval u_cond_eval (
      .cond  (cond),
      .Z     (Z),
      .N     (N),
      .V     (V),
      .taken (br_taken)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= S_RST;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      nsel       = NSEL_RM;
      loada      = 1'b0;
      loadb      = 1'b0;
      loadc      = 1'b0;
      loads      = 1'b0;
      write      = 1'b0;
      asel       = 1'b0;
      bsel       = 1'b0;
      vsel       = VSEL_C;
      load_ir    = 1'b0;
      load_pc    = 1'b0;
      reset_pc   = 1'b0;
      pc_sel     = 1'b0;
      addr_sel   = 1'b0;
      load_addr  = 1'b0;
      mem_cmd    = MEM_NONE;
      halted     = 1'b0;

      case (state)
         S_RST: begin
            reset_pc   = 1'b1;
            load_pc    = 1'b1;
            next_state = S_IF1;
         end
         S_IF1: begin
            addr_sel   = 1'b1;
            mem_cmd    = MEM_READ;
            next_state = S_IF2;
         end
         S_IF2: begin
            addr_sel   = 1'b1;
            mem_cmd    = MEM_READ;
            load_ir    = 1'b1;
            next_state = S_UPC;
         end
         S_UPC: begin
            load_pc    = 1'b1;
            next_state = S_DEC;
         end
         S_DEC: begin
            next_state = S_IF1;
            if (opcode == OPC_MOV && op == OP_MOVI) next_state = S_WIMM;
            else if (b_only(opcode, op))            next_state = S_GETB;
            else if (opcode == OPC_ALU || is_mem)   next_state = S_GETA;
            else if (opcode == OPC_BR)              next_state = S_BR;
            else if (opcode == OPC_HALT)            next_state = S_HALT;
         end
         S_WIMM: begin
            nsel       = NSEL_RN;
            vsel       = VSEL_IMM;
            write      = 1'b1;
            next_state = S_IF1;
         end
         S_GETA: begin
            nsel       = NSEL_RN;
            loada      = 1'b1;
            next_state = is_mem ? S_ADDR : S_GETB;
         end
         S_GETB: begin
            loadb      = 1'b1;
            next_state = S_ALU;
         end
         // CMP only updates the status register; everything else latches C.
         S_ALU: begin
            if (opcode == OPC_ALU && op == OP_CMP) begin
               loads      = 1'b1;
               next_state = S_IF1;
            end else begin
               loadc      = 1'b1;
               asel       = b_only(opcode, op);
               next_state = S_WREG;
            end
         end
         S_WREG: begin
            nsel       = NSEL_RD;
            vsel       = VSEL_C;
            write      = 1'b1;
            next_state = S_IF1;
         end
         S_ADDR: begin
            bsel       = 1'b1;
            loadc      = 1'b1;
            next_state = S_LADDR;
         end
         S_LADDR: begin
            load_addr  = 1'b1;
            next_state = (opcode == OPC_LDR) ? S_MRD : S_SGETB;
         end
         S_MRD: begin
            mem_cmd    = MEM_READ;
            next_state = S_MWB;
         end
         S_MWB: begin
            mem_cmd    = MEM_READ;
            vsel       = VSEL_MEM;
            nsel       = NSEL_RD;
            write      = 1'b1;
            next_state = S_IF1;
         end
         S_SGETB: begin
            nsel       = NSEL_RD;
            loadb      = 1'b1;
            next_state = S_SALU;
         end
         S_SALU: begin
            asel       = 1'b1;
            loadc      = 1'b1;
            next_state = S_SWR;
         end
         S_SWR: begin
            mem_cmd    = MEM_WRITE;
            next_state = S_IF1;
         end
         S_BR: begin
            load_pc    = br_taken;
            pc_sel     = br_taken;
            next_state = S_IF1;
         end
         S_HALT: begin
            halted     = 1'b1;
            next_state = S_HALT;
         end
         default: next_state = S_RST;
      endcase
   end

endmodule

// File: tb/tb_cpu_controller.sv
// Cycle-by-cycle scoreboard bench for cpu_controller output vectors.
module tb_cpu_controller;

   typedef struct packed {
      logic [2:0] nsel;
      logic       loada, loadb, loadc, loads, write, asel, bsel;
      logic [1:0] vsel;
      logic       load_ir, load_pc, reset_pc, pc_sel, addr_sel, load_addr;
      logic [1:0] mem_cmd;
      logic       halted;
   } ov_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] opcode, cond;
   logic [1:0] op;
   logic       Z, N, V;
   ov_t        act;

   ov_t   q_exp[$];
   string q_tag[$];
   int    n_chk  = 0;
   int    n_pass = 0;

   cpu_controller dut (
      .clk       (clk),
      .reset     (reset),
      .opcode    (opcode),
      .op        (op),
      .cond      (cond),
      .Z         (Z),
      .N         (N),
      .V         (V),
      .nsel      (act.nsel),
      .loada     (act.loada),
      .loadb     (act.loadb),
      .loadc     (act.loadc),
      .loads     (act.loads),
      .write     (act.write),
      .asel      (act.asel),
      .bsel      (act.bsel),
      .vsel      (act.vsel),
      .load_ir   (act.load_ir),
      .load_pc   (act.load_pc),
      .reset_pc  (act.reset_pc),
      .pc_sel    (act.pc_sel),
      .addr_sel  (act.addr_sel),
      .load_addr (act.load_addr),
      .mem_cmd   (act.mem_cmd),
      .halted    (act.halted)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input ov_t got, input ov_t exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%h exp=%h", tag, got, exp);
   endtask

   // Expected outputs of each named state, straight from the state table.
   function automatic ov_t st(input string s);
      ov_t e;
      e = '0;
      e.nsel = 3'b001;
      if (s == "IF1")        begin e.addr_sel = 1; e.mem_cmd = 2'b01; end
      else if (s == "IF2")   begin e.addr_sel = 1; e.mem_cmd = 2'b01; e.load_ir = 1; end
      else if (s == "UPC")   e.load_pc = 1;
      else if (s == "RST")   begin e.reset_pc = 1; e.load_pc = 1; end
      else if (s == "WIMM")  begin e.nsel = 3'b100; e.vsel = 2'b10; e.write = 1; end
      else if (s == "GETA")  begin e.nsel = 3'b100; e.loada = 1; end
      else if (s == "GETB")  e.loadb = 1;
      else if (s == "ALU1")  begin e.loadc = 1; e.asel = 1; end
      else if (s == "ALU0")  e.loadc = 1;
      else if (s == "CMP")   e.loads = 1;
      else if (s == "WREG")  begin e.nsel = 3'b010; e.write = 1; end
      else if (s == "ADDR")  begin e.bsel = 1; e.loadc = 1; end
      else if (s == "LADDR") e.load_addr = 1;
      else if (s == "MRD")   e.mem_cmd = 2'b01;
      else if (s == "MWB")   begin e.mem_cmd = 2'b01; e.vsel = 2'b11; e.nsel = 3'b010; e.write = 1; end
      else if (s == "SGETB") begin e.nsel = 3'b010; e.loadb = 1; end
      else if (s == "SALU")  begin e.asel = 1; e.loadc = 1; end
      else if (s == "SWR")   e.mem_cmd = 2'b10;
      else if (s == "BRT")   begin e.load_pc = 1; e.pc_sel = 1; end
      else if (s == "HALT")  e.halted = 1;
      return e;
   endfunction

   function automatic logic br_model(input logic [2:0] c, input logic z, n, v);
      case (c)
         3'd0: return 1'b1;
         3'd1: return z;
         3'd2: return !z;
         3'd3: return n != v;
         3'd4: return (n != v) || z;
         default: return 1'b0;
      endcase
   endfunction

   task automatic push(input string itag, input string s);
      q_exp.push_back(st(s));
      q_tag.push_back({itag, "/", s});
   endtask

   task automatic drain();
      while (q_exp.size() > 0) begin
         @(negedge clk);
         check_val(q_tag.pop_front(), act, q_exp.pop_front());
      end
   endtask

   task automatic apply(input logic [2:0] opc, input logic [1:0] o, input logic [2:0] c,
                        input logic z, n, v);
      @(posedge clk);
      #1;
      opcode = opc; op = o; cond = c; Z = z; N = n; V = v;
   endtask

   task automatic push_fetch(input string t);
      push(t, "IF1"); push(t, "IF2"); push(t, "UPC"); push(t, "DEC");
   endtask

   task automatic run(input string t, input logic [2:0] opc, input logic [1:0] o,
                      input logic [2:0] c, input logic z, n, v);
      apply(opc, o, c, z, n, v);
      push_fetch(t);
      if (opc == 3'b110 && o == 2'b10) push(t, "WIMM");
      else if ((opc == 3'b110 && o == 2'b00) || (opc == 3'b101 && o == 2'b11)) begin
         push(t, "GETB"); push(t, "ALU1"); push(t, "WREG");
      end else if (opc == 3'b101) begin
         push(t, "GETA"); push(t, "GETB");
         if (o == 2'b01) push(t, "CMP");
         else begin push(t, "ALU0"); push(t, "WREG"); end
      end else if (opc == 3'b011 && o == 2'b00) begin
         push(t, "GETA"); push(t, "ADDR"); push(t, "LADDR"); push(t, "MRD"); push(t, "MWB");
      end else if (opc == 3'b100 && o == 2'b00) begin
         push(t, "GETA"); push(t, "ADDR"); push(t, "LADDR");
         push(t, "SGETB"); push(t, "SALU"); push(t, "SWR");
      end else if (opc == 3'b001) push(t, br_model(c, z, n, v) ? "BRT" : "DEC");
      else if (opc == 3'b111) repeat (4) push(t, "HALT");
      drain();
   endtask

   task automatic do_reset(input string t);
      reset = 1'b1;
      push(t, "RST");
      drain();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      opcode = '0; op = '0; cond = '0; Z = 0; N = 0; V = 0;
      @(posedge clk);
      push("rst", "RST"); push("rst", "RST");
      drain();
      reset = 1'b0;

      run("movi",  3'b110, 2'b10, 3'd0, 0, 0, 0);
      run("movr",  3'b110, 2'b00, 3'd0, 0, 0, 0);
      run("mvn",   3'b101, 2'b11, 3'd0, 0, 0, 0);
      run("add",   3'b101, 2'b00, 3'd0, 0, 0, 0);
      run("and",   3'b101, 2'b10, 3'd0, 0, 0, 0);
      run("cmp",   3'b101, 2'b01, 3'd0, 0, 0, 0);
      run("ldr",   3'b011, 2'b00, 3'd0, 0, 0, 0);
      run("str",   3'b100, 2'b00, 3'd0, 0, 0, 0);
      run("nop0",  3'b000, 2'b00, 3'd0, 0, 0, 0);
      run("nop1",  3'b110, 2'b01, 3'd0, 0, 0, 0);
      run("nop2",  3'b011, 2'b01, 3'd0, 0, 0, 0);
      run("beqT",  3'b001, 2'b00, 3'd1, 1, 0, 0);
      run("beqN",  3'b001, 2'b00, 3'd1, 0, 0, 0);
      run("bleT",  3'b001, 2'b00, 3'd4, 0, 1, 0);
      run("bltN",  3'b001, 2'b00, 3'd3, 0, 1, 1);
      run("bnvr",  3'b001, 2'b00, 3'd7, 1, 1, 0);
      for (int i = 0; i < 16; i++)
         run("brnd", 3'b001, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      run("halt", 3'b111, 2'b00, 3'd0, 0, 0, 0);
      do_reset("hrst");
      run("movi2", 3'b110, 2'b10, 3'd0, 0, 0, 0);

      // Abort a store at SALU: the SWR write must never appear.
      apply(3'b100, 2'b00, 3'd0, 0, 0, 0);
      push_fetch("strab");
      push("strab", "GETA"); push("strab", "ADDR"); push("strab", "LADDR");
      push("strab", "SGETB"); push("strab", "SALU");
      drain();
      do_reset("srst");
      run("ldr2", 3'b011, 2'b00, 3'd0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; reset  in  1  synchronous, active-high.
REQ-002 SHALL have: opcode  in  3  from decoder, ir[15:13]; op  in  2  ir[12:11]; cond  in  3  ir[10:8].
REQ-003 SHALL have: Z, N, V  in  1 each  status flags from datapath status register.
REQ-004 SHALL have: nsel  out  3  one-hot register select to decoder (001 Rm, 010 Rd, 100 Rn).
REQ-005 SHALL have: loada, loadb, loadc, loads, write, asel, bsel  out  1 each  datapath controls.
REQ-006 SHALL have: vsel  out  2  writeback source (00 C, 01 PC, 10 sximm8, 11 mdata).
REQ-007 SHALL have: load_ir, load_pc, reset_pc, pc_sel, addr_sel, load_addr  out  1 each; mem_cmd  out  2 (00 NONE, 01 READ, 10 WRITE); halted  out  1.

Function
REQ-008 SHALL be a Moore FSM: state registered on clk; outputs combinational from current state plus opcode/op/cond/flags only.
REQ-009 SHALL default every output to 0 and nsel to 001 in any state not asserting it.
REQ-010 SHALL sequence RST -> IF1 -> IF2 -> UPC -> DEC unconditionally.
REQ-011 RST: reset_pc=1, load_pc=1. IF1: addr_sel=1, mem_cmd=READ. IF2: same as IF1 plus load_ir=1. UPC: load_pc=1, pc_sel=0. DEC: no asserts.
REQ-012 DEC SHALL dispatch: 110/10 -> WIMM; 110/00 -> GETB; 101/11 (MVN) -> GETB; 101/other -> GETA; 011/00, 100/00 -> GETA; 001/any -> BR; 111 -> HALT; all other codes -> IF1 (NOP).
REQ-013 WIMM: nsel=100, vsel=10, write=1 -> IF1.
REQ-014 GETA: nsel=100, loada=1 -> ADDR for LDR/STR, else GETB.
REQ-015 GETB: nsel=001, loadb=1 -> ALU.
REQ-016 ALU: loadc=1, asel=1 for 110/00 and MVN; CMP (101/01) SHALL assert loads=1, loadc=0 and go to IF1; others -> WREG.
REQ-017 WREG: nsel=010, vsel=00, write=1 -> IF1.
REQ-018 ADDR: asel=0, bsel=1, loadc=1 -> LADDR; LADDR: load_addr=1 -> MRD (LDR) or SGETB (STR).
REQ-019 MRD: addr_sel=0, mem_cmd=READ -> MWB; MWB: mem_cmd=READ, vsel=11, nsel=010, write=1 -> IF1.
REQ-020 SGETB: nsel=010, loadb=1 -> SALU (asel=1, bsel=0, loadc=1) -> SWR (addr_sel=0, mem_cmd=WRITE) -> IF1.
REQ-021 BR: taken per cond (000 always; 001 Z; 010 !Z; 011 N!=V; 100 (N!=V)|Z; others never) SHALL assert load_pc=1, pc_sel=1; -> IF1 either way.
REQ-022 HALT: halted=1, no other asserts; SHALL remain until reset.
REQ-023 Latency (cycles from IF1 entry to next IF1): MOV imm 5, MOV reg/MVN 7, ALU 8, CMP 7, LDR 9, STR 10, B 5.
REQ-024 Flags SHALL be sampled in BR only; a CMP completes (loads in ALU) before any following BR reaches DEC.

Reset
REQ-025 reset high at a clk edge SHALL force state RST from any state, including mid-instruction and HALT; no write/mem WRITE SHALL be asserted in the cycle following that edge.
REQ-026 State register SHALL have no asynchronous reset; power-up state undefined until first reset edge.

Structure
REQ-027 State encodings, mem_cmd codes, vsel codes, nsel one-hot constants, opcode/op values SHALL live in shared package cpu_defs, also used by datapath and decoder.
REQ-028 Branch-condition evaluation SHALL be sub-module cond_eval (cond, Z, N, V -> taken); nothing else instantiated.

Verification
REQ-029 reset 2 cycles then release -> RST outputs (reset_pc=1, load_pc=1) held, then IF1/IF2/UPC/DEC in 4 cycles, load_ir=1 only in IF2.
REQ-030 opcode=110, op=10 -> write=1, nsel=100, vsel=10 exactly one cycle, back in IF1 5 cycles after prior IF1.
REQ-031 opcode=101, op=01 (CMP) -> loads=1, write never asserted; opcode=101, op=00 -> write=1, vsel=00, nsel=010 in WREG.
REQ-032 STR (100/00) -> mem_cmd=10 with addr_sel=0 one cycle in SWR; LDR (011/00) -> vsel=11, write=1 in MWB.
REQ-033 B cond=001 with Z=1 -> load_pc=1, pc_sel=1; with Z=0 -> load_pc=0; cond=100, N=1, V=0, Z=0 -> taken.
REQ-034 opcode=111 -> halted=1 indefinitely; reset asserted during HALT and during STR SALU -> RST next cycle, no mem WRITE issued.
